// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution,
// load-use stall detection, wrong-path squashing and the EX/MEM register.
module ex_stage #(
  parameter int unsigned FLUSH_SHADOW = 2
) (
  input  logic        stg_clk,
  input  logic        reset_n,
  input  logic        stg_ena,
  input  logic [31:0] pc,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3_,
  input  logic [6:0]  funct7_,
  input  logic [31:0] imm,
  input  logic [3:0]  instr_type,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        save_to_reg,
  input  logic [4:0]  wb_rd,
  input  logic        wb_save,
  input  logic [31:0] wb_data,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_data_out,
  output logic [4:0]  rd_out,
  output logic [2:0]  funct3_out,
  output logic        save_to_reg_out,
  output logic        rd_memory_out,
  output logic        wr_memory_out,
  output logic        valid_out,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        hazard_stall
);

  typedef enum logic [3:0] {
    IT_NOP    = 4'd0,
    IT_R      = 4'd1,
    IT_IALU   = 4'd2,
    IT_LOAD   = 4'd3,
    IT_STORE  = 4'd4,
    IT_BRANCH = 4'd5,
    IT_JAL    = 4'd6,
    IT_JALR   = 4'd7,
    IT_LUI    = 4'd8,
    IT_AUIPC  = 4'd9
  } itype_e;

  itype_e      itype;
  logic [1:0]  shadow_cnt;
  logic        live, use_rs1, use_rs2, exec;
  logic        mem_a, mem_b, wb_a, wb_b, lu_a, lu_b;
  logic [31:0] op_a, op_b, alu_b, alu_res, target;
  logic [4:0]  shamt;
  logic        take;
  logic        unused_funct7;

  assign itype         = itype_e'(instr_type);
  assign unused_funct7 = ^{funct7_[6], funct7_[4:0]};

  always_comb begin
    live    = (instr_type >= 4'd1) && (instr_type <= 4'd9) && (shadow_cnt == '0);
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (itype)
      IT_R, IT_STORE, IT_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      IT_IALU, IT_LOAD, IT_JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  // Loads in EX/MEM have no data yet: they never forward, they stall instead.
  assign mem_a = (rs1 != '0) && valid_out && save_to_reg_out && !rd_memory_out && (rd_out == rs1);
  assign mem_b = (rs2 != '0) && valid_out && save_to_reg_out && !rd_memory_out && (rd_out == rs2);
  assign wb_a  = (rs1 != '0) && wb_save && (wb_rd == rs1);
  assign wb_b  = (rs2 != '0) && wb_save && (wb_rd == rs2);
  assign lu_a  = use_rs1 && (rs1 != '0) && valid_out && rd_memory_out && (rd_out == rs1);
  assign lu_b  = use_rs2 && (rs2 != '0) && valid_out && rd_memory_out && (rd_out == rs2);

  assign op_a = mem_a ? alu_result_out : (wb_a ? wb_data : rs1_data);
  assign op_b = mem_b ? alu_result_out : (wb_b ? wb_data : rs2_data);

  assign hazard_stall = live && (lu_a || lu_b);
  assign exec         = live && !hazard_stall;

  always_comb begin
    alu_b   = (itype == IT_R) ? op_b : imm;
    shamt   = alu_b[4:0];
    alu_res = '0;
    take    = 1'b0;
    target  = pc + imm;
    case (itype)
      IT_R, IT_IALU: begin
        case (funct3_)
          3'b000:  alu_res = (itype == IT_R && funct7_[5]) ? op_a - alu_b : op_a + alu_b;
          3'b001:  alu_res = op_a << shamt;
          3'b010:  alu_res = {31'b0, $signed(op_a) < $signed(alu_b)};
          3'b011:  alu_res = {31'b0, op_a < alu_b};
          3'b100:  alu_res = op_a ^ alu_b;
          3'b101:  alu_res = funct7_[5] ? $unsigned($signed(op_a) >>> shamt) : op_a >> shamt;
          3'b110:  alu_res = op_a | alu_b;
          default: alu_res = op_a & alu_b;
        endcase
      end
      IT_LOAD, IT_STORE: alu_res = op_a + imm;
      IT_BRANCH: begin
        case (funct3_)
          3'b000:  take = (op_a == op_b);
          3'b001:  take = (op_a != op_b);
          3'b100:  take = ($signed(op_a) < $signed(op_b));
          3'b101:  take = ($signed(op_a) >= $signed(op_b));
          3'b110:  take = (op_a < op_b);
          3'b111:  take = (op_a >= op_b);
          default: take = 1'b0;
        endcase
      end
      IT_JAL: begin
        alu_res = pc + 32'd4;
        take    = 1'b1;
      end
      IT_JALR: begin
        alu_res = pc + 32'd4;
        take    = 1'b1;
        target  = (op_a + imm) & ~32'd1;
      end
      IT_LUI:   alu_res = imm;
      IT_AUIPC: alu_res = pc + imm;
      default: ;
    endcase
  end

  always_ff @(posedge stg_clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_result_out  <= '0;
      store_data_out  <= '0;
      rd_out          <= '0;
      funct3_out      <= '0;
      save_to_reg_out <= 1'b0;
      rd_memory_out   <= 1'b0;
      wr_memory_out   <= 1'b0;
      valid_out       <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= '0;
      shadow_cnt      <= '0;
    end else if (stg_ena) begin
      redirect_valid <= 1'b0;
      if (exec) begin
        alu_result_out  <= alu_res;
        store_data_out  <= op_b;
        rd_out          <= rd;
        funct3_out      <= funct3_;
        save_to_reg_out <= save_to_reg;
        rd_memory_out   <= (itype == IT_LOAD);
        wr_memory_out   <= (itype == IT_STORE);
        valid_out       <= 1'b1;
        if (take) begin
          redirect_valid <= 1'b1;
          redirect_pc    <= target;
          shadow_cnt     <= 2'(FLUSH_SHADOW);
        end
      end else begin
        alu_result_out  <= '0;
        store_data_out  <= '0;
        rd_out          <= '0;
        funct3_out      <= '0;
        save_to_reg_out <= 1'b0;
        rd_memory_out   <= 1'b0;
        wr_memory_out   <= 1'b0;
        valid_out       <= 1'b0;
        // A stalled live slot is not in the shadow, so this only counts squashes.
        if (shadow_cnt != '0) shadow_cnt <= shadow_cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, reset sequence, and randomized
// traffic compared against an instruction-level reference model.
module tb_ex_stage;

  logic        stg_clk = 1'b0;
  logic        reset_n;
  logic        stg_ena;
  logic [31:0] pc, imm, rs1_data, rs2_data, wb_data;
  logic [4:0]  rd, rs1, rs2, wb_rd;
  logic [2:0]  funct3_;
  logic [6:0]  funct7_;
  logic [3:0]  instr_type;
  logic        save_to_reg, wb_save;
  logic [31:0] alu_result_out, store_data_out, redirect_pc;
  logic [4:0]  rd_out;
  logic [2:0]  funct3_out;
  logic        save_to_reg_out, rd_memory_out, wr_memory_out, valid_out;
  logic        redirect_valid, hazard_stall;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage #(.FLUSH_SHADOW(2)) dut (
    .stg_clk(stg_clk), .reset_n(reset_n), .stg_ena(stg_ena), .pc(pc), .rd(rd),
    .rs1(rs1), .rs2(rs2), .funct3_(funct3_), .funct7_(funct7_), .imm(imm),
    .instr_type(instr_type), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .save_to_reg(save_to_reg), .wb_rd(wb_rd), .wb_save(wb_save), .wb_data(wb_data),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out), .rd_out(rd_out),
    .funct3_out(funct3_out), .save_to_reg_out(save_to_reg_out),
    .rd_memory_out(rd_memory_out), .wr_memory_out(wr_memory_out), .valid_out(valid_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .hazard_stall(hazard_stall)
  );

  always #5 stg_clk = ~stg_clk;

  typedef struct {
    logic [3:0]  t;
    logic [4:0]  rd, rs1, rs2, wbrd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm, pc, d1, d2, wbd;
    logic        save, wbs, ena;
  } in_t;

  typedef struct {
    in_t         in;
    logic        x_stall, x_valid, x_rv, chk_alu;
    logic [31:0] x_rpc, x_alu;
    logic [4:0]  x_rd;
  } vec_t;

  typedef struct {
    logic [31:0] alu, sd, rpc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        save, rdm, wrm, valid, rv;
    int          shadow;
  } st_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic [3:0] t, input logic [4:0] d, input logic [4:0] s1,
                             input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [31:0] im, input logic [31:0] v1, input logic [31:0] v2,
                             input logic [31:0] p);
    in_t r;
    r.t = t; r.rd = d; r.rs1 = s1; r.rs2 = s2; r.f3 = f3; r.f7 = f7; r.imm = im;
    r.d1 = v1; r.d2 = v2; r.pc = p; r.wbs = 1'b0; r.wbrd = '0; r.wbd = '0; r.ena = 1'b1;
    r.save = (t inside {4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9});
    return r;
  endfunction

  function automatic vec_t mv(input in_t i, input logic st, input logic v, input logic rv,
                              input logic [31:0] rpc, input logic ca, input logic [31:0] alu,
                              input logic [4:0] xrd);
    vec_t r;
    r.in = i; r.x_stall = st; r.x_valid = v; r.x_rv = rv; r.x_rpc = rpc;
    r.chk_alu = ca; r.x_alu = alu; r.x_rd = xrd;
    return r;
  endfunction

  task automatic apply(input in_t v);
    instr_type = v.t; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; funct3_ = v.f3; funct7_ = v.f7;
    imm = v.imm; pc = v.pc; rs1_data = v.d1; rs2_data = v.d2; save_to_reg = v.save;
    wb_save = v.wbs; wb_rd = v.wbrd; wb_data = v.wbd; stg_ena = v.ena;
  endtask

  // Reference model: one instruction slot per enabled cycle, straight from the ISA rules.
  function automatic logic [31:0] fwd(input st_t s, input in_t v, input logic [4:0] r,
                                      input logic [31:0] rf);
    if (r == 0) return rf;
    if (s.valid && s.save && !s.rdm && s.rd == r) return s.alu;
    if (v.wbs && v.wbrd == r) return v.wbd;
    return rf;
  endfunction

  function automatic logic model_stall(input st_t s, input in_t v);
    logic live, u1, u2;
    live = (v.t >= 1 && v.t <= 9) && s.shadow == 0;
    u1 = v.t inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7};
    u2 = v.t inside {4'd1, 4'd4, 4'd5};
    return live && ((u1 && v.rs1 != 0 && s.valid && s.rdm && s.rd == v.rs1) ||
                     (u2 && v.rs2 != 0 && s.valid && s.rdm && s.rd == v.rs2));
  endfunction

  function automatic st_t model_next(input st_t s, input in_t v);
    st_t n;
    logic [31:0] a, b, y;
    logic taken;
    if (!v.ena) return s;
    n = s;
    n.rv = 0;
    n.alu = 0; n.sd = 0; n.rd = 0; n.f3 = 0; n.save = 0; n.rdm = 0; n.wrm = 0; n.valid = 0;
    if (s.shadow > 0) begin
      n.shadow = s.shadow - 1;
      return n;
    end
    if (!(v.t >= 1 && v.t <= 9) || model_stall(s, v)) return n;
    a = fwd(s, v, v.rs1, v.d1);
    b = fwd(s, v, v.rs2, v.d2);
    y = 0;
    taken = 0;
    if (v.t == 1 || v.t == 2) begin
      logic [31:0] o;
      o = (v.t == 1) ? b : v.imm;
      case (v.f3)
        0: y = (v.t == 1 && v.f7[5]) ? a + (~o + 1) : a + o;
        1: y = a << o[4:0];
        2: y = (int'(a) < int'(o)) ? 1 : 0;
        3: y = (a < o) ? 1 : 0;
        4: y = a ^ o;
        5: y = v.f7[5] ? 32'(int'(a) >>> o[4:0]) : a >> o[4:0];
        6: y = a | o;
        default: y = a & o;
      endcase
    end else if (v.t == 3 || v.t == 4) y = a + v.imm;
    else if (v.t == 6 || v.t == 7) begin
      y = v.pc + 4;
      taken = 1;
    end else if (v.t == 8) y = v.imm;
    else if (v.t == 9) y = v.pc + v.imm;
    else if (v.t == 5) begin
      case (v.f3)
        0: taken = (a == b);
        1: taken = (a != b);
        4: taken = int'(a) < int'(b);
        5: taken = int'(a) >= int'(b);
        6: taken = a < b;
        7: taken = a >= b;
        default: taken = 0;
      endcase
    end
    n.alu = y; n.sd = b; n.rd = v.rd; n.f3 = v.f3; n.save = v.save;
    n.rdm = (v.t == 3); n.wrm = (v.t == 4); n.valid = 1;
    if (taken) begin
      n.rv = 1;
      n.rpc = (v.t == 7) ? ((a + v.imm) & 32'hFFFF_FFFE) : v.pc + v.imm;
      n.shadow = 2;
    end
    return n;
  endfunction

  vec_t tbl[$];
  in_t  v;
  st_t  ms;

  initial begin
    reset_n = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    chk("reset_valid", {31'b0, valid_out}, 0);
    chk("reset_alu", alu_result_out, 0);
    chk("reset_rv", {31'b0, redirect_valid}, 0);
    @(negedge stg_clk);
    reset_n = 1'b1;
    @(posedge stg_clk); #1;

    tbl.push_back(mv(mk(1, 3, 1, 2, 0, 0, 0, 5, 7, 0), 0, 1, 0, 0, 1, 12, 3));
    tbl.push_back(mv(mk(1, 3, 1, 2, 0, 7'h20, 0, 5, 7, 0), 0, 1, 0, 0, 1, 32'hFFFF_FFFE, 3));
    tbl.push_back(mv(mk(2, 5, 0, 0, 0, 0, 10, 0, 0, 0), 0, 1, 0, 0, 1, 10, 5));
    v = mk(2, 6, 5, 0, 0, 0, 1, 0, 0, 0); v.wbs = 1; v.wbrd = 5; v.wbd = 99;
    tbl.push_back(mv(v, 0, 1, 0, 0, 1, 11, 6));
    tbl.push_back(mv(mk(3, 4, 0, 0, 3'b010, 0, 32'h80, 0, 0, 0), 0, 1, 0, 0, 1, 32'h80, 4));
    tbl.push_back(mv(mk(1, 7, 4, 1, 0, 0, 0, 0, 1, 0), 1, 0, 0, 0, 0, 0, 0));
    v = mk(1, 7, 4, 1, 0, 0, 0, 0, 1, 0); v.wbs = 1; v.wbrd = 4; v.wbd = 20;
    tbl.push_back(mv(v, 0, 1, 0, 0, 1, 21, 7));
    tbl.push_back(mv(mk(5, 0, 1, 2, 0, 0, 32'h20, 3, 3, 32'h100), 0, 1, 1, 32'h120, 1, 0, 0));
    tbl.push_back(mv(mk(1, 9, 1, 2, 0, 0, 0, 1, 2, 0), 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mv(mk(1, 9, 1, 2, 0, 0, 0, 1, 2, 0), 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mv(mk(1, 8, 1, 2, 0, 0, 0, 1, 2, 0), 0, 1, 0, 0, 1, 3, 8));
    tbl.push_back(mv(mk(5, 0, 1, 2, 3'b001, 0, 32'h40, 3, 3, 32'h200), 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mv(mk(7, 1, 1, 0, 0, 0, 4, 32'h203, 0, 32'h40), 0, 1, 1, 32'h206, 1, 32'h44, 1));
    for (int k = 0; k < 3; k++) begin
      v = mk(1, 2, 1, 2, 0, 0, 0, 9, 9, 0); v.ena = 0;
      tbl.push_back(mv(v, 0, 1, 1, 32'h206, 1, 32'h44, 1));
    end
    tbl.push_back(mv(mk(1, 10, 1, 2, 0, 0, 0, 5, 7, 0), 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mv(mk(1, 10, 1, 2, 0, 0, 0, 5, 7, 0), 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mv(mk(1, 11, 1, 2, 0, 0, 0, 5, 7, 0), 0, 1, 0, 0, 1, 12, 11));
    tbl.push_back(mv(mk(2, 0, 0, 0, 0, 0, 5, 0, 0, 0), 0, 1, 0, 0, 1, 5, 0));
    tbl.push_back(mv(mk(1, 12, 0, 0, 0, 0, 0, 7, 8, 0), 0, 1, 0, 0, 1, 15, 12));
    tbl.push_back(mv(mk(3, 0, 0, 0, 0, 0, 32'h10, 0, 0, 0), 0, 1, 0, 0, 1, 32'h10, 0));
    tbl.push_back(mv(mk(1, 13, 0, 0, 0, 0, 0, 1, 2, 0), 0, 1, 0, 0, 1, 3, 13));

    foreach (tbl[i]) begin
      apply(tbl[i].in);
      #1;
      chk($sformatf("v%0d_stall", i), {31'b0, hazard_stall}, {31'b0, tbl[i].x_stall});
      @(posedge stg_clk); #1;
      chk($sformatf("v%0d_valid", i), {31'b0, valid_out}, {31'b0, tbl[i].x_valid});
      chk($sformatf("v%0d_rv", i), {31'b0, redirect_valid}, {31'b0, tbl[i].x_rv});
      if (tbl[i].x_rv) chk($sformatf("v%0d_rpc", i), redirect_pc, tbl[i].x_rpc);
      if (tbl[i].chk_alu) begin
        chk($sformatf("v%0d_alu", i), alu_result_out, tbl[i].x_alu);
        chk($sformatf("v%0d_rd", i), {27'b0, rd_out}, {27'b0, tbl[i].x_rd});
      end
    end

    // Reset mid-stream with a redirect and shadow pending.
    apply(mk(6, 1, 0, 0, 0, 0, 32'h10, 0, 0, 32'h300));
    @(posedge stg_clk); #1;
    chk("jal_rv", {31'b0, redirect_valid}, 1);
    chk("jal_rpc", redirect_pc, 32'h310);
    chk("jal_link", alu_result_out, 32'h304);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_alu", alu_result_out, 0);
    chk("arst_valid", {31'b0, valid_out}, 0);
    chk("arst_rv", {31'b0, redirect_valid}, 0);
    chk("arst_rpc", redirect_pc, 0);
    chk("arst_save", {31'b0, save_to_reg_out}, 0);
    chk("arst_rd", {27'b0, rd_out}, 0);
    @(negedge stg_clk);
    reset_n = 1'b1;
    apply(mk(1, 7, 4, 1, 0, 0, 0, 30, 4, 0));
    #1;
    chk("post_rst_stall", {31'b0, hazard_stall}, 0);
    @(posedge stg_clk); #1;
    chk("post_rst_valid", {31'b0, valid_out}, 1);
    chk("post_rst_alu", alu_result_out, 34);

    // Randomized traffic against the model.
    reset_n = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 reset_n = 1'b1;
    ms = '{alu: 0, sd: 0, rpc: 0, rd: 0, f3: 0, save: 0, rdm: 0, wrm: 0, valid: 0, rv: 0, shadow: 0};
    @(posedge stg_clk); #1;
    for (int c = 0; c < 3000; c++) begin
      v.t = 4'($urandom_range(0, 11));
      v.rd = 5'($urandom_range(0, 5)); v.rs1 = 5'($urandom_range(0, 5)); v.rs2 = 5'($urandom_range(0, 5));
      v.f3 = 3'($urandom_range(0, 7)); v.f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      v.imm = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 64));
      v.pc = $urandom & 32'hFFFF_FFFC;
      v.d1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      v.d2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      v.save = $urandom_range(0, 3) != 0;
      v.wbs = $urandom_range(0, 1) != 0; v.wbrd = 5'($urandom_range(0, 5)); v.wbd = $urandom;
      v.ena = $urandom_range(0, 9) != 0;
      apply(v);
      #1;
      chk("rnd_stall", {31'b0, hazard_stall}, {31'b0, model_stall(ms, v)});
      ms = model_next(ms, v);
      @(posedge stg_clk); #1;
      chk("rnd_valid", {31'b0, valid_out}, {31'b0, ms.valid});
      chk("rnd_save", {31'b0, save_to_reg_out}, {31'b0, ms.save});
      chk("rnd_rdm", {31'b0, rd_memory_out}, {31'b0, ms.rdm});
      chk("rnd_wrm", {31'b0, wr_memory_out}, {31'b0, ms.wrm});
      chk("rnd_rv", {31'b0, redirect_valid}, {31'b0, ms.rv});
      if (ms.rv) chk("rnd_rpc", redirect_pc, ms.rpc);
      if (ms.valid) begin
        chk("rnd_alu", alu_result_out, ms.alu);
        chk("rnd_sd", store_data_out, ms.sd);
        chk("rnd_rd", {27'b0, rd_out}, {27'b0, ms.rd});
        chk("rnd_f3", {29'b0, funct3_out}, {29'b0, ms.f3});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
